// File: rtl/fp_sched_pkg.sv
// Shared types and constants for the fp_add_sched scheduler.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package fp_sched_pkg;

  // Upper bound on the add unit latency; sizes the EXEC cycle counter.
  localparam int ADD_LATENCY_MAX = 8;

  typedef logic [31:0] fp32_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_e;

  // One requester's operation as presented on its request port.
  typedef struct packed {
    fp32_t op1;
    fp32_t op2;
    logic  sub;
  } fp_req_t;

  // a - b is issued as a + (-b): only the sign bit of b changes.
  function automatic fp32_t fp_apply_sub(input fp32_t op, input logic sub);
    return {op[31] ^ sub, op[30:0]};
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector: a lone request always wins, a tie goes to ptr.
// Latency: combinational.
// Backpressure: none; grant is zero when no request is present.
// Ports: req[1:0] requests, ptr preferred requester on a tie, grant[1:0] one-hot.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/fp_add_sched.sv
// Schedules two requesters onto one shared FP add unit, one operation in flight.
// Latency: ADD_LATENCY+1 cycles from the accept cycle to rsp_valid; issue interval ADD_LATENCY+2.
// Backpressure: result is held in RESP until the owner's rsp_ready; new requests wait meanwhile.
// Ports: clk/n_rst; req_valid/ready/op1/op2/sub per requester (_0/_1); add_op1/add_op2 to
// the add unit, add_result/add_overflow back; rsp_valid/ready per requester, shared rsp_result/
// rsp_overflow. Optional FP_ADD_SCHED_STATS_EN adds stat_grant_0/1 saturating accept counters.
module fp_add_sched
  import fp_sched_pkg::*;
#(
  parameter int ADD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        req_valid_0,
  input  logic        req_valid_1,
  output logic        req_ready_0,
  output logic        req_ready_1,
  input  logic [31:0] req_op1_0,
  input  logic [31:0] req_op2_0,
  input  logic [31:0] req_op1_1,
  input  logic [31:0] req_op2_1,
  input  logic        req_sub_0,
  input  logic        req_sub_1,
  output logic [31:0] add_op1,
  output logic [31:0] add_op2,
  input  logic [31:0] add_result,
  input  logic        add_overflow,
  output logic        rsp_valid_0,
  output logic        rsp_valid_1,
  input  logic        rsp_ready_0,
  input  logic        rsp_ready_1,
  output logic [31:0] rsp_result,
  output logic        rsp_overflow
`ifdef FP_ADD_SCHED_STATS_EN
  ,
  output logic [15:0] stat_grant_0,
  output logic [15:0] stat_grant_1
`endif
);

  localparam int CNT_W = $clog2(ADD_LATENCY_MAX);
  localparam logic [CNT_W-1:0] EXEC_LAST = CNT_W'(ADD_LATENCY - 1);

  sched_state_e     state;
  logic             rr_ptr;
  logic             owner;
  logic [CNT_W-1:0] exec_cnt;

  logic [1:0] grant;
  logic       accept;
  logic       rsp_done;
  fp_req_t    req_0;
  fp_req_t    req_1;
  fp_req_t    req_sel;

  assign req_0 = {req_op1_0, req_op2_0, req_sub_0};
  assign req_1 = {req_op1_1, req_op2_1, req_sub_1};

  rr_arb2 u_arb (
    .req   ({req_valid_1, req_valid_0}),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  always_comb begin
    req_sel = grant[1] ? req_1 : req_0;
  end

  // Grant is one-hot on an asserted valid, so any grant in IDLE is a handshake.
  assign accept   = (state == IDLE) && (grant != 2'b00);
  assign rsp_done = (rsp_valid_0 && rsp_ready_0) || (rsp_valid_1 && rsp_ready_1);

  // Ready is combinational on the incoming valids; n_rst gates it so a requester
  // holding valid through reset never sees ready before release.
  assign req_ready_0 = n_rst && (state == IDLE) && grant[0];
  assign req_ready_1 = n_rst && (state == IDLE) && grant[1];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      rr_ptr       <= 1'b0;
      owner        <= 1'b0;
      exec_cnt     <= '0;
      add_op1      <= '0;
      add_op2      <= '0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
      rsp_valid_0  <= 1'b0;
      rsp_valid_1  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner    <= grant[1];
            add_op1  <= req_sel.op1;
            add_op2  <= fp_apply_sub(req_sel.op2, req_sel.sub);
            exec_cnt <= '0;
            state    <= EXEC;
          end
        end
        EXEC: begin
          // Operands stay untouched here so the add unit sees them stable for
          // the full ADD_LATENCY window; the result is taken on its last edge.
          if (exec_cnt == EXEC_LAST) begin
            rsp_result   <= add_result;
            rsp_overflow <= add_overflow;
            rsp_valid_0  <= ~owner;
            rsp_valid_1  <= owner;
            state        <= RESP;
          end else begin
            exec_cnt <= exec_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_done) begin
            rsp_valid_0 <= 1'b0;
            rsp_valid_1 <= 1'b0;
            // Favour the other requester on the next tie.
            rr_ptr      <= ~owner;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FP_ADD_SCHED_STATS_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      stat_grant_0 <= '0;
      stat_grant_1 <= '0;
    end else if (accept) begin
      if (grant[0] && (stat_grant_0 != 16'hFFFF)) begin
        stat_grant_0 <= stat_grant_0 + 16'd1;
      end
      if (grant[1] && (stat_grant_1 != 16'hFFFF)) begin
        stat_grant_1 <= stat_grant_1 + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/fp_add_sched.md
FP_ADD_SCHED -- requirements
Module: fp_add_sched

Interface
REQ-001 SHALL have parameter ADD_LATENCY, default 1, meaning the number of cycles the add unit needs from stable operands to valid result (legal range 1-8).
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-003 SHALL have port n_rst, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have ports req_valid_0 and req_valid_1, input, 1 bit each: requester operand-valid.
REQ-005 SHALL have ports req_ready_0 and req_ready_1, output, 1 bit each: requester accept.
REQ-006 SHALL have ports req_op1_0, req_op2_0, req_op1_1 and req_op2_1, input, 32 bits each: IEEE-754 single-precision operands.
REQ-007 SHALL have ports req_sub_0 and req_sub_1, input, 1 bit each: 1 means op1-op2.
REQ-008 SHALL have ports add_op1 and add_op2, output, 32 bits each: operands driven to the shared add unit.
REQ-009 SHALL have ports add_result (input, 32 bits) and add_overflow (input, 1 bit): add unit outputs.
REQ-010 SHALL have ports rsp_valid_0 and rsp_valid_1, output, 1 bit each: response valid per requester.
REQ-011 SHALL have ports rsp_ready_0 and rsp_ready_1, input, 1 bit each: response accept per requester.
REQ-012 SHALL have ports rsp_result (output, 32 bits) and rsp_overflow (output, 1 bit): response payload, shared by both requesters.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC and RESP.
REQ-014 IDLE: req_ready_x = 1 only for the arbitration winner among asserted req_valid_x; no valid request keeps the FSM in IDLE with both ready signals 0.
REQ-015 Arbitration SHALL be round-robin: a single request always wins; on simultaneous requests the requester indicated by rr_ptr wins.
REQ-016 rr_ptr SHALL point to the non-winner after each completed response; its reset value is 0.
REQ-017 On accept (valid&ready), operands SHALL be registered, with op2[31] inverted when req_sub=1; the FSM then moves to EXEC.
REQ-018 EXEC SHALL last exactly ADD_LATENCY cycles, with add_op1/add_op2 held stable from the registers throughout.
REQ-019 On the final EXEC edge, add_result and add_overflow SHALL be captured and the FSM moves to RESP.
REQ-020 RESP: rsp_valid_x SHALL be asserted for the owning requester only, with rsp_result/rsp_overflow stable, until rsp_ready_x=1.
REQ-021 On the RESP handshake edge the FSM SHALL return to IDLE, giving latency from accept edge to rsp_valid high of ADD_LATENCY+1 cycles.
REQ-022 Minimum issue interval SHALL be ADD_LATENCY+2 cycles, with exactly one operation in flight at a time.
REQ-023 A requester's req_valid changes while it is not granted SHALL have no effect, and requests arriving in EXEC/RESP SHALL wait.
REQ-024 rsp_ready asserted in the same cycle rsp_valid first rises SHALL complete the response in that cycle.

Reset
REQ-025 n_rst=0 SHALL asynchronously force state=IDLE, rr_ptr=0, every valid/ready output to 0, add_op1/add_op2/rsp_result to 0 and rsp_overflow to 0.
REQ-026 Reset mid-EXEC or mid-RESP SHALL drop the transaction with no response after release.

Configuration
REQ-027 With FP_ADD_SCHED_STATS_EN defined, the block SHALL add outputs stat_grant_0 and stat_grant_1 (16 bits each): saturating accept counters, reset to 0.
REQ-028 Without FP_ADD_SCHED_STATS_EN, those ports and counters SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-029 Package fp_sched_pkg SHALL hold the fp32_t typedef, the FSM state enum and the constant ADD_LATENCY_MAX=8.
REQ-030 Two-way round-robin selection SHALL live in sub-module rr_arb2 (inputs req[1:0] and ptr; output one-hot grant[1:0]).

Verification
REQ-031 Requester 0: op1=0x3F800000 (1.0), op2=0x40000000 (2.0), sub=0, model add unit returning 0x40400000 -> rsp_valid_0 at accept+ADD_LATENCY+1 with rsp_result=0x40400000.
REQ-032 Requester 1, sub=1, op2=0x40000000 -> add_op2=0xC0000000 throughout EXEC.
REQ-033 Both requesters valid at reset release -> grant order 0,1,0,1 over four back-to-back operations.
REQ-034 rsp_ready_0 held low for 5 cycles in RESP -> rsp_valid_0 and rsp_result stable for all 5, with no new grant issued.
REQ-035 n_rst pulsed during EXEC with ADD_LATENCY=4 -> no rsp_valid after release, then the next request is served normally by requester 0.
REQ-036 With FP_ADD_SCHED_STATS_EN, 70000 grants to requester 0 -> stat_grant_0=0xFFFF.
